// File: rtl/bus_pkg.sv
// Shared definitions for the bus master port and its arbiter: default
// parameter values, the master FSM state encoding and the result codes.
package bus_pkg;

  localparam int BUS_ADDR_WIDTH      = 16;
  localparam int BUS_DATA_WIDTH      = 16;
  localparam int BUS_CLK_MAX_TIMEOUT = 10;

  // ST_BACKOFF is only reachable when the retry option is built in.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DATA    = 3'd3,
    ST_DONE    = 3'd4,
    ST_BACKOFF = 3'd5
  } state_t;

  typedef logic [1:0] err_t;

  localparam err_t ERR_OK       = 2'b00;
  localparam err_t ERR_ARB      = 2'b01;
  localparam err_t ERR_GRANT_TO = 2'b10;
  localparam err_t ERR_XFER_TO  = 2'b11;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Wait-phase timer. Counts enabled cycles, saturates at MAX and flags the
// cycle in which the MAX-th enabled cycle of the current phase is running.
module bus_timeout_cnt
  import bus_pkg::*;
#(
  parameter int MAX = BUS_CLK_MAX_TIMEOUT
) (
  input  logic clk,
  input  logic clrn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             W    = $clog2(MAX + 1);
  localparam logic [W-1:0]   LAST = W'(MAX - 1);
  localparam logic [W-1:0]   SAT  = W'(MAX);

  logic [W-1:0] count;

  // Cycle counter: cleared on phase change, saturating while enabled.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + W'(1);
    end
  end

  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/bus_master_port.sv
// Single-transfer bus master: request/grant, address phase, data phase,
// with error, grant-loss and timeout handling.
// Optional feature: define BUS_MASTER_RETRY_EN to retry a failed transfer
// once after dropping the bus request for two cycles.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH      = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH      = BUS_DATA_WIDTH,
  parameter int CLK_MAX_TIMEOUT = BUS_CLK_MAX_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  start_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  barq_o,
  input  logic                  bagd_i,
  output logic                  address_valid_o,
  input  logic                  target_ready_i,
  input  logic                  data_strobe_i,
  input  logic [1:0]            error_i,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic                  bus_we_o,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

  state_t                state_q, state_n;
  err_t                  err_q, err_n, fail_code;
  logic                  fail, capture;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  tmr_clear, tmr_en, tmr_expired;
`ifdef BUS_MASTER_RETRY_EN
  logic                  retried_q;
  logic                  bo_cnt_q;
`endif

  // Next-state and result decode; error_i outranks grant loss, handshakes
  // and timeouts in every bus-owning state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_n   = state_q;
    err_n     = err_q;
    fail      = 1'b0;
    fail_code = ERR_OK;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i) state_n = ST_REQ;
      ST_REQ: begin
        if (error_i != 2'b00)  begin fail = 1'b1; fail_code = ERR_ARB; end
        else if (bagd_i)       state_n = ST_ADDR;
        else if (tmr_expired)  begin fail = 1'b1; fail_code = ERR_GRANT_TO; end
      end
      ST_ADDR: begin
        if (error_i != 2'b00)    begin fail = 1'b1; fail_code = ERR_ARB; end
        else if (!bagd_i)        begin fail = 1'b1; fail_code = ERR_ARB; end
        else if (target_ready_i) state_n = ST_DATA;
        else if (tmr_expired)    begin fail = 1'b1; fail_code = ERR_XFER_TO; end
      end
      ST_DATA: begin
        if (error_i != 2'b00)   begin fail = 1'b1; fail_code = ERR_ARB; end
        else if (!bagd_i)       begin fail = 1'b1; fail_code = ERR_ARB; end
        else if (data_strobe_i) begin
          capture = !we_q;
          state_n = ST_DONE;
          err_n   = ERR_OK;
        end
        else if (tmr_expired)   begin fail = 1'b1; fail_code = ERR_XFER_TO; end
      end
      ST_DONE: state_n = ST_IDLE;
`ifdef BUS_MASTER_RETRY_EN
      ST_BACKOFF: if (bo_cnt_q) state_n = ST_REQ;
`endif
      default: state_n = ST_IDLE;
    endcase
    if (fail) begin
`ifdef BUS_MASTER_RETRY_EN
      if (!retried_q) begin
        state_n = ST_BACKOFF;
      end else begin
        state_n = ST_DONE;
        err_n   = fail_code;
      end
`else
      state_n = ST_DONE;
      err_n   = fail_code;
`endif
    end
  end

  // The address and data phases share one wait budget, so the move from
  // ADDR to DATA does not restart the timer.
  assign tmr_clear = (state_n != state_q) && !((state_q == ST_ADDR) && (state_n == ST_DATA));
  assign tmr_en    = (state_q == ST_REQ) || (state_q == ST_ADDR) || (state_q == ST_DATA);

  bus_timeout_cnt #(.MAX(CLK_MAX_TIMEOUT)) u_timer (
    .clk     (clk),
    .clrn    (clrn),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  // State, latched transfer fields, result code and read data registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_OK;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_n;
      err_q   <= err_n;
      if ((state_q == ST_IDLE) && start_i) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (capture) rdata_q <= bus_rdata_i;
    end
  end

`ifdef BUS_MASTER_RETRY_EN
  // Retry bookkeeping: one retry per transfer, two-cycle request backoff.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      retried_q <= 1'b0;
      bo_cnt_q  <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && start_i) retried_q <= 1'b0;
      else if (fail && !retried_q)         retried_q <= 1'b1;
      bo_cnt_q <= (state_q == ST_BACKOFF) && !bo_cnt_q;
    end
  end
`endif

  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = (state_q == ST_DONE);
  assign err_o           = done_o ? err_q : ERR_OK;
  assign rdata_o         = rdata_q;
  assign barq_o          = tmr_en;
  assign address_valid_o = (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign bus_addr_o      = address_valid_o ? addr_q  : '0;
  assign bus_wdata_o     = address_valid_o ? wdata_q : '0;
  assign bus_we_o        = address_valid_o && we_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: read, grant timeout, error with strobe,
// grant loss plus start-in-DONE, transfer timeout, and reset mid-transfer.
// Expectations follow BUS_MASTER_RETRY_EN when it is defined.
module tb_bus_master_port;

  logic        clk = 1'b0;
  logic        clrn;
  logic        start_i, we_i;
  logic [15:0] addr_i, wdata_i;
  logic        busy_o, done_o;
  logic [1:0]  err_o;
  logic [15:0] rdata_o;
  logic        barq_o, bagd_i, address_valid_o, target_ready_i, data_strobe_i;
  logic [1:0]  error_i;
  logic [15:0] bus_addr_o, bus_wdata_o;
  logic        bus_we_o;
  logic [15:0] bus_rdata_i;

  int n_vec = 0;
  int n_bad = 0;
  int cyc, nb;

  bus_master_port #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .CLK_MAX_TIMEOUT(10)) dut (
    .clk(clk), .clrn(clrn), .start_i(start_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rdata_o(rdata_o), .barq_o(barq_o), .bagd_i(bagd_i),
    .address_valid_o(address_valid_o), .target_ready_i(target_ready_i),
    .data_strobe_i(data_strobe_i), .error_i(error_i), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_we_o(bus_we_o), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; bagd_i = 0;
    target_ready_i = 0; data_strobe_i = 0; error_i = 2'b00; bus_rdata_i = '0;
  endtask

  // Presents start for one cycle; returns at cycle 1 (first REQ cycle).
  task automatic start_xfer(input logic we, input logic [15:0] a, input logic [15:0] d);
    start_i = 1; we_i = we; addr_i = a; wdata_i = d;
    tick();
    start_i = 0;
  endtask

  // Bounded wait for done_o; o_cyc is the cycle number of the DONE cycle,
  // o_nb the number of cycles barq_o was seen high before it.
  task automatic wait_done(input int from, input int budget, output int o_cyc, output int o_nb);
    o_cyc = from;
    o_nb  = 0;
    while (!done_o && o_cyc < budget) begin
      if (barq_o) o_nb++;
      tick();
      o_cyc++;
    end
    check("done_seen", 32'(done_o), 32'd1);
  endtask

  initial begin
    idle_inputs();
    clrn = 0;
    #12;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_barq", 32'(barq_o), 32'd0);
    check("rst_rdata", 32'(rdata_o), 32'd0);
    clrn = 1;
    tick();

    // Read: grant at 3, ready at 5, strobe at 6 -> done at 7.
    start_xfer(1'b0, 16'h0123, 16'h0000);
    check("rd_busy_c1", 32'(busy_o), 32'd1);
    check("rd_barq_c1", 32'(barq_o), 32'd1);
    tick();
    tick(); bagd_i = 1;
    tick();
    check("rd_av_c4", 32'(address_valid_o), 32'd1);
    check("rd_addr_c4", 32'(bus_addr_o), 32'h0123);
    check("rd_we_c4", 32'(bus_we_o), 32'd0);
    tick(); target_ready_i = 1;
    tick(); target_ready_i = 0; data_strobe_i = 1; bus_rdata_i = 16'hBEEF;
    check("rd_done_c6", 32'(done_o), 32'd0);
    tick(); data_strobe_i = 0; bagd_i = 0;
    check("rd_done_c7", 32'(done_o), 32'd1);
    check("rd_err", 32'(err_o), 32'd0);
    check("rd_rdata", 32'(rdata_o), 32'hBEEF);
    check("rd_barq_done", 32'(barq_o), 32'd0);
    check("rd_av_done", 32'(address_valid_o), 32'd0);
    check("rd_addr_done", 32'(bus_addr_o), 32'd0);
    tick();
    check("rd_done_c8", 32'(done_o), 32'd0);
    check("rd_busy_c8", 32'(busy_o), 32'd0);

    // No grant: barq for 10 cycles then err 10.
    start_xfer(1'b0, 16'h0042, 16'h0000);
    wait_done(1, 60, cyc, nb);
    check("gto_err", 32'(err_o), 32'h2);
`ifdef BUS_MASTER_RETRY_EN
    check("gto_barq_cycles", 32'(nb), 32'd20);
    check("gto_done_cycle", 32'(cyc), 32'd23);
`else
    check("gto_barq_cycles", 32'(nb), 32'd10);
    check("gto_done_cycle", 32'(cyc), 32'd11);
`endif
    tick();

    // Error with strobe in DATA: err 01, rdata keeps 0xBEEF.
    bagd_i = 1; target_ready_i = 1;
    start_xfer(1'b0, 16'h0077, 16'h0000);
    tick();
    check("err_av_c2", 32'(address_valid_o), 32'd1);
    tick();
    data_strobe_i = 1; error_i = 2'b10; bus_rdata_i = 16'h1234;
    wait_done(3, 60, cyc, nb);
    check("err_code", 32'(err_o), 32'h1);
    check("err_rdata_kept", 32'(rdata_o), 32'hBEEF);
    idle_inputs();
    tick();

    // Write, grant drops in ADDR; start pulsed during DONE is ignored.
    bagd_i = 1;
    start_xfer(1'b1, 16'hA5A5, 16'h3C3C);
    tick();
    check("gl_we", 32'(bus_we_o), 32'd1);
    check("gl_wdata", 32'(bus_wdata_o), 32'h3C3C);
    check("gl_addr", 32'(bus_addr_o), 32'hA5A5);
    bagd_i = 0;
    wait_done(2, 60, cyc, nb);
`ifdef BUS_MASTER_RETRY_EN
    check("gl_err", 32'(err_o), 32'h2);
`else
    check("gl_err", 32'(err_o), 32'h1);
    check("gl_done_cycle", 32'(cyc), 32'd3);
`endif
    start_i = 1;
    tick(); start_i = 0;
    check("done_start_busy", 32'(busy_o), 32'd0);
    tick();
    check("done_start_barq", 32'(barq_o), 32'd0);
    check("done_start_idle", 32'(busy_o), 32'd0);

    // Grant but no ready: ADDR waits 10 cycles then err 11.
    bagd_i = 1;
    start_xfer(1'b0, 16'h0100, 16'h0000);
    wait_done(1, 60, cyc, nb);
    check("xto_err", 32'(err_o), 32'h3);
`ifdef BUS_MASTER_RETRY_EN
    check("xto_done_cycle", 32'(cyc), 32'd25);
`else
    check("xto_done_cycle", 32'(cyc), 32'd12);
`endif
    idle_inputs();
    tick();

    // Reset asserted in DATA, then a fresh read completes.
    bagd_i = 1; target_ready_i = 1;
    start_xfer(1'b0, 16'h0200, 16'h0000);
    tick(); tick();
    check("rst_in_data_av", 32'(address_valid_o), 32'd1);
    #2 clrn = 0;
    #1;
    check("arst_barq", 32'(barq_o), 32'd0);
    check("arst_av", 32'(address_valid_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_rdata", 32'(rdata_o), 32'd0);
    check("arst_addr", 32'(bus_addr_o), 32'd0);
    idle_inputs();
    tick();
    check("arst_no_done", 32'(done_o), 32'd0);
    #3 clrn = 1;
    tick();
    bagd_i = 1; target_ready_i = 1; data_strobe_i = 1; bus_rdata_i = 16'h5A5A;
    start_xfer(1'b0, 16'h0300, 16'h0000);
    wait_done(1, 60, cyc, nb);
    check("post_rst_err", 32'(err_o), 32'h0);
    check("post_rst_rdata", 32'(rdata_o), 32'h5A5A);
    check("post_rst_cycle", 32'(cyc), 32'd4);
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
